// File: rtl/dev_b_pkg.sv
// rtl/dev_b_pkg.sv - shared types and default constants for the device-B receiver
package dev_b_pkg;
    localparam int DATA_W     = 8;
    localparam int DEPTH      = 4;
    localparam int ACK_CYCLES = 2;

    localparam logic SRC_A1 = 1'b0;
    localparam logic SRC_A2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        ACK,
        WAIT_LOW
    } rxStateT;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through circular FIFO with exact occupancy count
module sync_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clkB,
    input  logic          rst,
    input  logic          wrEn,
    input  logic [W-1:0]  wrData,
    input  logic          rdEn,
    output logic [W-1:0]  rdData,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] cnt;
    logic          doRd;
    logic          doWr;

    // A pop frees the slot in the same edge, so a push into a full FIFO is legal alongside it.
    assign doRd = rdEn && (cnt != '0);
    assign doWr = wrEn && ((cnt != CW'(DEPTH)) || doRd);

    always_ff @(posedge clkB) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doWr) begin
                mem[wrPtr] <= wrData;
                wrPtr      <= wrPtr + AW'(1);
            end
            if (doRd) begin
                rdPtr <= rdPtr + AW'(1);
            end
            if (doWr && !doRd) begin
                cnt <= cnt + CW'(1);
            end else if (doRd && !doWr) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign rdData = mem[rdPtr];
    assign empty  = (cnt == '0);
    assign full   = (cnt == CW'(DEPTH));
    assign count  = cnt;
endmodule

// File: rtl/dev_b_receiver.sv
// rtl/dev_b_receiver.sv - captures sharedBus on a requester's ready rise, tags the source and acknowledges
module dev_b_receiver
    import dev_b_pkg::*;
#(
    parameter int DATA_W     = dev_b_pkg::DATA_W,
    parameter int DEPTH      = dev_b_pkg::DEPTH,
    parameter int ACK_CYCLES = dev_b_pkg::ACK_CYCLES,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic              clkB,
    input  logic              rst,
    input  logic [DATA_W-1:0] sharedBus,
    input  logic              readyA1,
    input  logic              readyA2,
    output logic              acceptedB,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_src,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count
);
    localparam int AKW = $clog2(ACK_CYCLES + 1);

    rxStateT       state;
    logic [1:0]    syncA1;
    logic [1:0]    syncA2;
    logic          dlyA1;
    logic          dlyA2;
    logic          pendA1;
    logic          pendA2;
    logic          curSrc;
    logic [AKW-1:0] ackCnt;
    logic          riseA1;
    logic          riseA2;
    logic          evA1;
    logic          anyEv;
    logic          selSrc;
    logic          servedReady;
    logic          wrEn;
    logic [DATA_W:0] wrData;
    logic [DATA_W:0] rdWord;

    assign riseA1      = syncA1[1] & ~dlyA1;
    assign riseA2      = syncA2[1] & ~dlyA2;
    assign evA1        = riseA1 | pendA1;
    assign anyEv       = evA1 | riseA2 | pendA2;
    assign selSrc      = evA1 ? SRC_A1 : SRC_A2;
    assign servedReady = (curSrc == SRC_A2) ? syncA2[1] : syncA1[1];

    // The bus is sampled raw: the owning requester holds it for as long as its ready is high.
    assign wrData = {((state == IDLE) ? selSrc : curSrc), sharedBus};

    always_comb begin
        wrEn = 1'b0;
        case (state)
            IDLE:    wrEn = anyEv && !full;
            STALL:   wrEn = !full || rd_en;
            default: wrEn = 1'b0;
        endcase
    end

    always_ff @(posedge clkB) begin
        if (!rst) begin
            state     <= IDLE;
            syncA1    <= '0;
            syncA2    <= '0;
            dlyA1     <= 1'b0;
            dlyA2     <= 1'b0;
            pendA1    <= 1'b0;
            pendA2    <= 1'b0;
            curSrc    <= SRC_A1;
            ackCnt    <= '0;
            acceptedB <= 1'b0;
        end else begin
            syncA1 <= {syncA1[0], readyA1};
            syncA2 <= {syncA2[0], readyA2};
            dlyA1  <= syncA1[1];
            dlyA2  <= syncA2[1];
            pendA1 <= pendA1 | riseA1;
            pendA2 <= pendA2 | riseA2;
            case (state)
                IDLE: begin
                    if (anyEv) begin
                        curSrc <= selSrc;
                        ackCnt <= '0;
                        if (selSrc == SRC_A1) begin
                            pendA1 <= 1'b0;
                        end else begin
                            pendA2 <= 1'b0;
                        end
                        state <= full ? STALL : ACK;
                    end
                end
                STALL: begin
                    if (wrEn) begin
                        ackCnt <= '0;
                        state  <= ACK;
                    end
                end
                ACK: begin
                    if (ackCnt == AKW'(ACK_CYCLES)) begin
                        acceptedB <= 1'b0;
                        state     <= WAIT_LOW;
                    end else begin
                        acceptedB <= 1'b1;
                        ackCnt    <= ackCnt + AKW'(1);
                    end
                end
                WAIT_LOW: begin
                    // One ready pulse must yield one capture, so wait for it to drop first.
                    if (!servedReady) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clkB   (clkB),
        .rst    (rst),
        .wrEn   (wrEn),
        .wrData (wrData),
        .rdEn   (rd_en),
        .rdData (rdWord),
        .empty  (empty),
        .full   (full),
        .count  (count)
    );

    assign rd_src  = rdWord[DATA_W];
    assign rd_data = rdWord[DATA_W-1:0];
endmodule

// File: tb/tb_dev_b_receiver.sv
// tb/tb_dev_b_receiver.sv - directed and random stimulus against a transaction-level receiver model
module tb_dev_b_receiver;
    localparam int DW = 8;
    localparam int DP = 4;
    localparam int AK = 2;
    localparam int CW = $clog2(DP) + 1;

    logic          clkB = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] sharedBus = '0;
    logic          readyA1 = 1'b0;
    logic          readyA2 = 1'b0;
    logic          rd_en = 1'b0;
    logic          acceptedB;
    logic [DW-1:0] rd_data;
    logic          rd_src;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;

    always #5 clkB = ~clkB;

    dev_b_receiver #(.DATA_W(DW), .DEPTH(DP), .ACK_CYCLES(AK)) dut (
        .clkB(clkB), .rst(rst), .sharedBus(sharedBus), .readyA1(readyA1), .readyA2(readyA2),
        .acceptedB(acceptedB), .rd_en(rd_en), .rd_data(rd_data), .rd_src(rd_src),
        .empty(empty), .full(full), .count(count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: ready history per source, expected queue contents, and service timing.
    logic [8:0] mq[$];
    bit  mS1[2], mS2[2], mS3[2], mPend[2];
    int  mAckLeft = 0;
    bit  mWaitLow = 0, mHold = 0, mSrc = 0, mAcc = 0, started = 0;
    int  mWrites = 0;

    always @(posedge clkB) begin
        bit rise[2];
        bit have, sel, doPush, pop;
        int sz;
        started = 1;
        if (!rst) begin
            mq.delete();
            for (int s = 0; s < 2; s++) begin
                mS1[s] = 0; mS2[s] = 0; mS3[s] = 0; mPend[s] = 0;
            end
            mAckLeft = 0; mWaitLow = 0; mHold = 0; mAcc = 0; mWrites = 0;
        end else begin
            for (int s = 0; s < 2; s++) rise[s] = mS2[s] && !mS3[s];
            have = rise[0] || mPend[0] || rise[1] || mPend[1];
            sel = (rise[0] || mPend[0]) ? 1'b0 : 1'b1;
            sz = mq.size();
            pop = rd_en && (sz > 0);
            doPush = 0;
            for (int s = 0; s < 2; s++) mPend[s] = mPend[s] || rise[s];
            if (mAckLeft > 0) begin
                mAckLeft--;
                mAcc = (mAckLeft > 0);
                if (mAckLeft == 0) mWaitLow = 1;
            end else if (mWaitLow) begin
                if (!mS2[mSrc]) mWaitLow = 0;
            end else if (mHold) begin
                if (sz < DP || rd_en) begin doPush = 1; mHold = 0; end
            end else if (have) begin
                mSrc = sel;
                mPend[sel] = 0;
                if (sz < DP) doPush = 1; else mHold = 1;
            end
            if (pop) void'(mq.pop_front());
            if (doPush) begin
                mq.push_back({mSrc, sharedBus});
                mAckLeft = AK + 1;
                mWrites++;
            end
            for (int s = 0; s < 2; s++) begin mS3[s] = mS2[s]; mS2[s] = mS1[s]; end
            mS1[0] = readyA1;
            mS1[1] = readyA2;
        end
    end

    always @(negedge clkB) begin
        if (started) begin
            chk("acceptedB", acceptedB, mAcc);
            chk("count", count, mq.size());
            chk("empty", empty, mq.size() == 0);
            chk("full", full, mq.size() == DP);
            if (mq.size() > 0) begin
                chk("rd_data", rd_data, mq[0][7:0]);
                chk("rd_src", rd_src, mq[0][8]);
            end else if (mWrites == 0) begin
                chk("rd_data_rst", rd_data, 0);
                chk("rd_src_rst", rd_src, 0);
            end
        end
    end

    int accPulses = 0;
    bit accPrev = 0;
    always @(posedge clkB) begin
        if (acceptedB && !accPrev) accPulses++;
        accPrev = acceptedB;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clkB);
    endtask

    task automatic wait_ack_done(input string name);
        int n = 0;
        while (!acceptedB && n < 60) begin @(negedge clkB); n++; end
        while (acceptedB && n < 60) begin @(negedge clkB); n++; end
        chk(name, n < 60, 1);
    endtask

    task automatic xfer_a1(input logic [7:0] d);
        sharedBus = d;
        readyA1 = 1'b1;
        wait_ack_done("xfer_ack");
        readyA1 = 1'b0;
        cyc(6);
    endtask

    task automatic pop_check(input logic [7:0] d, input logic s);
        chk("pop_data", rd_data, d);
        chk("pop_src", rd_src, s);
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    initial begin
        int n;
        // Reset held with A1 ready high, then exactly one capture after release
        @(negedge clkB);
        rst = 1'b0; readyA1 = 1'b1; sharedBus = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clkB);
            chk("rst_acc", acceptedB, 0);
            chk("rst_empty", empty, 1);
            chk("rst_count", count, 0);
        end
        accPulses = 0;
        rst = 1'b1;
        cyc(20);
        chk("rst_rel_count", count, 1);
        chk("rst_rel_data", rd_data, 8'h99);
        chk("rst_rel_pulses", accPulses, 1);
        readyA1 = 1'b0;
        cyc(6);
        pop_check(8'h99, 1'b0);

        // Single transfer
        accPulses = 0;
        xfer_a1(8'hA5);
        chk("single_data", rd_data, 8'hA5);
        chk("single_src", rd_src, 0);
        chk("single_count", count, 1);
        chk("single_pulses", accPulses, 1);
        pop_check(8'hA5, 1'b0);

        // Simultaneous rises: A1 first, pending A2 second
        accPulses = 0;
        sharedBus = 8'h3C; readyA1 = 1'b1; readyA2 = 1'b1;
        wait_ack_done("sim_ack1");
        readyA1 = 1'b0; sharedBus = 8'h7E;
        wait_ack_done("sim_ack2");
        readyA2 = 1'b0;
        cyc(6);
        chk("sim_count", count, 2);
        chk("sim_pulses", accPulses, 2);
        pop_check(8'h3C, 1'b0);
        pop_check(8'h7E, 1'b1);

        // Full stall, then simultaneous pop and push
        xfer_a1(8'h11); xfer_a1(8'h22); xfer_a1(8'h33); xfer_a1(8'h44);
        chk("fill_full", full, 1);
        accPulses = 0;
        sharedBus = 8'h55; readyA2 = 1'b1;
        cyc(10);
        chk("stall_acc", acceptedB, 0);
        chk("stall_pulses", accPulses, 0);
        chk("stall_count", count, 4);
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        chk("stall_swap_count", count, 4);
        wait_ack_done("stall_ack");
        readyA2 = 1'b0;
        cyc(6);
        chk("stall_pulses2", accPulses, 1);
        pop_check(8'h22, 1'b0); pop_check(8'h33, 1'b0);
        pop_check(8'h44, 1'b0); pop_check(8'h55, 1'b1);

        // Held ready yields one capture until it falls and rises again
        accPulses = 0;
        sharedBus = 8'h66; readyA1 = 1'b1;
        cyc(20);
        chk("held_count", count, 1);
        chk("held_pulses", accPulses, 1);
        readyA1 = 1'b0;
        cyc(6);
        xfer_a1(8'h67);
        chk("held_count2", count, 2);
        chk("held_pulses2", accPulses, 2);
        pop_check(8'h66, 1'b0); pop_check(8'h67, 1'b0);

        // Pop while empty, then reset during ACK
        rd_en = 1'b1;
        cyc(3);
        rd_en = 1'b0;
        chk("empty_pop_count", count, 0);
        sharedBus = 8'h88; readyA1 = 1'b1;
        n = 0;
        while (!acceptedB && n < 60) begin @(negedge clkB); n++; end
        chk("midack_seen", n < 60, 1);
        rst = 1'b0; readyA1 = 1'b0;
        cyc(1);
        chk("midack_acc", acceptedB, 0);
        chk("midack_count", count, 0);
        rst = 1'b1;
        cyc(8);
        chk("midack_after", count, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clkB);
            if ($urandom_range(0, 9) == 0) readyA1 = ~readyA1;
            if ($urandom_range(0, 9) == 0) readyA2 = ~readyA2;
            if (!readyA1 && !readyA2) sharedBus = 8'($urandom);
            rd_en = ($urandom_range(0, 3) == 0);
        end
        readyA1 = 1'b0; readyA2 = 1'b0; rd_en = 1'b1;
        cyc(40);
        rd_en = 1'b0;
        cyc(2);
        chk("drain_empty", empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
